// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, parameter checks and sizing helpers for the flop FIFO
package fifo_pkg;
  typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic bit params_ok(int depth, int af_th, int ae_th);
    return depth >= 2 && ae_th >= 0 && ae_th < af_th && af_th <= depth;
  endfunction
  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: modulo-depth wrapping pointer
module fifo_ptr #(
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_inc,
  output logic [$clog2(depth)-1:0] o_ptr
);
  localparam int PW = $clog2(depth);
  // advance on accept, wrapping from depth-1 back to 0 for any depth
  always_ff @(posedge clk)
    o_ptr <= rst ? '0 : !i_inc ? o_ptr : (o_ptr == PW'(depth - 1)) ? '0 : o_ptr + 1'b1;
endmodule

// File: rtl/fifo_flops_prog.sv
// fifo_flops_prog: flop FIFO with programmable thresholds, count, sticky errors and FWFT option
module fifo_flops_prog import fifo_pkg::*; #(
  parameter int depth = 16,
  parameter int bits  = 8,
  parameter int af_th = 12,
  parameter int ae_th = 4,
  parameter int fwft  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [bits-1:0]            Din,
  output logic [bits-1:0]            Dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [cnt_w(depth)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);
  localparam int CW = cnt_w(depth);
  localparam int AW = $clog2(depth);
  localparam fifo_mode_e MODE = (fwft != 0) ? FIFO_FWFT : FIFO_STD;

  if (!params_ok(depth, af_th, ae_th)) begin : g_bad_params
    $error("fifo_flops_prog: need depth >= 2 and 0 <= ae_th < af_th <= depth");
  end

  logic [bits-1:0] r_mem [depth];
  logic [AW-1:0]   w_wr_ptr, w_rd_ptr;
  logic            w_pop_acc, w_push_acc;
  logic [CW-1:0]   w_cnt_next;

  assign w_pop_acc  = pop & ~empty;
  assign w_push_acc = push & (~full | w_pop_acc);
  assign w_cnt_next = count + CW'(w_push_acc) - CW'(w_pop_acc);

  fifo_ptr #(.depth(depth)) u_wr_ptr (.clk(clk), .rst(rst), .i_inc(w_push_acc), .o_ptr(w_wr_ptr));
  fifo_ptr #(.depth(depth)) u_rd_ptr (.clk(clk), .rst(rst), .i_inc(w_pop_acc),  .o_ptr(w_rd_ptr));

  // storage is never reset; only accepted pushes write
  always_ff @(posedge clk)
    if (w_push_acc) r_mem[w_wr_ptr] <= Din;

  // occupancy, flags from the next count, and sticky errors where a new violation beats clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= w_cnt_next;
      empty        <= w_cnt_next == '0;
      full         <= w_cnt_next == CW'(depth);
      almost_full  <= w_cnt_next >= CW'(af_th);
      almost_empty <= w_cnt_next <= CW'(ae_th);
      overflow     <= (push & ~w_push_acc) | (overflow & ~clr_err);
      underflow    <= (pop & empty) | (underflow & ~clr_err);
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign Dout = empty ? '0 : r_mem[w_rd_ptr];
  end else begin : g_std
    // registered read: head word lands on Dout the cycle after an accepted pop
    always_ff @(posedge clk)
      if (rst) Dout <= '0;
      else if (w_pop_acc) Dout <= r_mem[w_rd_ptr];
  end
endmodule

// File: tb/tb_fifo_flops_prog.sv
// tb_fifo_flops_prog: three FIFO configurations on shared stimulus, checked against a queue-style model
module tb_fifo_flops_prog;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_i, push, pop, clr;
  logic [7:0] din;
  logic [2:0] full, empty, af, ae, ovf, unf;
  logic [7:0] d0, d1, d2;
  logic [4:0] c0, c1;
  logic [3:0] c2;
  int checks = 0, fails = 0;

  fifo_flops_prog #(.depth(16), .bits(8), .af_th(12), .ae_th(4), .fwft(0)) u_std (
    .clk(clk), .rst(rst_i), .push(push), .pop(pop), .Din(din), .Dout(d0), .full(full[0]),
    .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(c0),
    .overflow(ovf[0]), .underflow(unf[0]), .clr_err(clr));
  fifo_flops_prog #(.depth(16), .bits(8), .af_th(12), .ae_th(4), .fwft(1)) u_fwft (
    .clk(clk), .rst(rst_i), .push(push), .pop(pop), .Din(din), .Dout(d1), .full(full[1]),
    .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(c1),
    .overflow(ovf[1]), .underflow(unf[1]), .clr_err(clr));
  fifo_flops_prog #(.depth(12), .bits(8), .af_th(9), .ae_th(2), .fwft(0)) u_wrap (
    .clk(clk), .rst(rst_i), .push(push), .pop(pop), .Din(din), .Dout(d2), .full(full[2]),
    .empty(empty[2]), .almost_full(af[2]), .almost_empty(ae[2]), .count(c2),
    .overflow(ovf[2]), .underflow(unf[2]), .clr_err(clr));

  int D[3]  = '{16, 16, 12};
  int AF[3] = '{12, 12, 9};
  int AE[3] = '{4, 4, 2};
  bit FW[3] = '{0, 1, 0};

  logic [7:0] mq [3][16];
  int         msz [3];
  logic       mov [3], mun [3];
  logic [7:0] mdo [3];

  function automatic logic [18:0] dut_st(int k);
    logic [4:0] c;
    logic [7:0] d;
    c = (k == 0) ? c0 : (k == 1) ? c1 : {1'b0, c2};
    d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
    return {c, full[k], empty[k], af[k], ae[k], ovf[k], unf[k], d};
  endfunction

  function automatic logic [18:0] exp_st(int k);
    int sz;
    logic [7:0] d;
    sz = msz[k];
    d = FW[k] ? ((sz > 0) ? mq[k][0] : 8'h00) : mdo[k];
    return {5'(sz), sz == D[k], sz == 0, sz >= AF[k], sz <= AE[k], mov[k], mun[k], d};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst_i) begin
        msz[k] = 0; mov[k] = 0; mun[k] = 0; mdo[k] = 0;
      end else begin
        bit pop_ok, push_ok;
        pop_ok  = pop && msz[k] > 0;
        push_ok = push && (msz[k] < D[k] || pop_ok);
        mov[k] = (push && !push_ok) || (mov[k] && !clr);
        mun[k] = (pop && msz[k] == 0) || (mun[k] && !clr);
        if (pop_ok) begin
          if (!FW[k]) mdo[k] = mq[k][0];
          for (int j = 0; j < 15; j++) mq[k][j] = mq[k][j+1];
          msz[k]--;
        end
        if (push_ok) begin
          mq[k][msz[k]] = din;
          msz[k]++;
        end
      end
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c, input logic r);
    push = p; pop = q; din = d; clr = c; rst_i = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_st(k) !== exp_st(k)) begin
        fails++; $display("FAIL reset inst%0d got=%h exp=%h", k, dut_st(k), exp_st(k));
      end
    end
    checks++;
    if ({c0, empty[0], full[0], ae[0], af[0], ovf[0], unf[0], d0} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++; $display("FAIL reset_const got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b d=%h exp 0 1 0 1 0 0 0 00",
        c0, empty[0], full[0], ae[0], af[0], ovf[0], unf[0], d0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0, 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_st(k) !== exp_st(k)) begin
          fails++; $display("FAIL fill[%0d] inst%0d got=%h exp=%h", i, k, dut_st(k), exp_st(k));
        end
      end
      checks++;
      if (ae[0] !== (i + 1 <= 4) || af[0] !== (i + 1 >= 12) || ovf[0] !== 1'b0) begin
        fails++; $display("FAIL fill_flags[%0d] got ae=%b af=%b ov=%b exp ae=%b af=%b ov=0",
          i, ae[0], af[0], ovf[0], i + 1 <= 4, i + 1 >= 12);
      end
    end
    checks++;
    if (c0 !== 5'd16 || full[0] !== 1'b1) begin
      fails++; $display("FAIL fill_full got cnt=%0d full=%b exp 16 1", c0, full[0]);
    end
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp_d;
    step(1, 0, 8'hAA, 0, 0);
    checks++;
    if (ovf[0] !== 1'b1 || c0 !== 5'd16) begin
      fails++; $display("FAIL full_reject got ov=%b cnt=%0d exp 1 16", ovf[0], c0);
    end
    step(1, 1, 8'h55, 0, 0);
    checks++;
    if (c0 !== 5'd16 || d0 !== 8'h00) begin
      fails++; $display("FAIL full_pushpop got cnt=%0d dout=%h exp 16 00", c0, d0);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0);
      exp_d = (i < 15) ? 8'(i + 1) : 8'h55;
      checks++;
      if (d0 !== exp_d) begin
        fails++; $display("FAIL drain[%0d] got=%h exp=%h", i, d0, exp_d);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_st(k) !== exp_st(k)) begin
          fails++; $display("FAIL drain[%0d] inst%0d got=%h exp=%h", i, k, dut_st(k), exp_st(k));
        end
      end
    end
  endtask

  task automatic test_empty_errors();
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (unf[0] !== 1'b1 || c0 !== 5'd0 || d0 !== 8'h55) begin
      fails++; $display("FAIL empty_pop got un=%b cnt=%0d dout=%h exp 1 0 55", unf[0], c0, d0);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (unf[0] !== 1'b0) begin
      fails++; $display("FAIL clr_err got un=%b exp 0", unf[0]);
    end
    step(0, 1, 0, 1, 0);
    checks++;
    if (unf[0] !== 1'b1) begin
      fails++; $display("FAIL clr_vs_set got un=%b exp 1", unf[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_st(k) !== exp_st(k)) begin
        fails++; $display("FAIL errors inst%0d got=%h exp=%h", k, dut_st(k), exp_st(k));
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 8'(i), 0, 0);
      checks++;
      if (c2 !== 4'd1) begin
        fails++; $display("FAIL wrap_cnt1[%0d] got=%0d exp=1", i, c2);
      end
      step(0, 1, 0, 0, 0);
      checks++;
      if (d2 !== 8'(i) || c2 !== 4'd0) begin
        fails++; $display("FAIL wrap_data[%0d] got dout=%h cnt=%0d exp %h 0", i, d2, c2, 8'(i));
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_st(k) !== exp_st(k)) begin
          fails++; $display("FAIL wrap[%0d] inst%0d got=%h exp=%h", i, k, dut_st(k), exp_st(k));
        end
      end
    end
  endtask

  task automatic test_fwft();
    step(0, 0, 0, 0, 1);
    step(1, 0, 8'h3C, 0, 0);
    checks++;
    if (d1 !== 8'h3C || empty[1] !== 1'b0) begin
      fails++; $display("FAIL fwft_first got dout=%h empty=%b exp 3c 0", d1, empty[1]);
    end
    step(1, 0, 8'h3D, 0, 0);
    checks++;
    if (d1 !== 8'h3C) begin
      fails++; $display("FAIL fwft_hold got=%h exp=3c", d1);
    end
    step(0, 1, 0, 0, 0);
    checks++;
    if (d1 !== 8'h3D) begin
      fails++; $display("FAIL fwft_pop1 got=%h exp=3d", d1);
    end
    step(0, 1, 0, 0, 0);
    checks++;
    if (d1 !== 8'h00 || empty[1] !== 1'b1) begin
      fails++; $display("FAIL fwft_pop2 got dout=%h empty=%b exp 00 1", d1, empty[1]);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 8'($urandom), 0, 0);
    step(1, 0, 8'h99, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (c0 !== 5'd7) begin
      fails++; $display("FAIL mid_pre got cnt=%0d exp 7", c0);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({c0, empty[0], ae[0], af[0], full[0], ovf[0], unf[0], d0, d1} !== {5'd0, 4'b1100, 2'b00, 8'h00, 8'h00}) begin
      fails++; $display("FAIL mid_reset got cnt=%0d e=%b ae=%b af=%b f=%b ov=%b un=%b d=%h fd=%h exp 0 1 1 0 0 0 0 00 00",
        c0, empty[0], ae[0], af[0], full[0], ovf[0], unf[0], d0, d1);
    end
    step(1, 0, 8'h11, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++;
    if (d0 !== 8'h11 || c0 !== 5'd0) begin
      fails++; $display("FAIL mid_after got dout=%h cnt=%0d exp 11 0", d0, c0);
    end
  endtask

  task automatic test_random();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_st(k) !== exp_st(k)) begin
          fails++; $display("FAIL rand[%0d] inst%0d got=%h exp=%h", i, k, dut_st(k), exp_st(k));
        end
      end
    end
  endtask

  initial begin
    push = 0; pop = 0; din = 0; clr = 0; rst_i = 1;
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0; mov[k] = 0; mun[k] = 0; mdo[k] = 0;
    end
    test_reset();
    test_fill();
    test_full_boundary();
    test_empty_errors();
    test_wrap();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
